// File: rtl/tetris_pkg.sv
// Shared types, colours and screen constants for the Tetris pixel pipeline.
package tetris_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t COL_TEXT   = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
    localparam rgb_t COL_PAUSE  = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
    localparam rgb_t COL_PIECE  = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
    localparam rgb_t COL_LOCKED = '{r: 8'hFF, g: 8'h14, b: 8'h93};
    localparam rgb_t COL_BORDER = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
    localparam rgb_t COL_BG     = '{r: 8'h00, g: 8'h00, b: 8'h00};

    localparam logic [7:0] ASC_S     = 8'h53;
    localparam logic [7:0] ASC_C     = 8'h43;
    localparam logic [7:0] ASC_O     = 8'h4F;
    localparam logic [7:0] ASC_R     = 8'h52;
    localparam logic [7:0] ASC_E     = 8'h45;
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_ZERO  = 8'h30;

    localparam int unsigned GLYPH_W = 8;
    localparam int unsigned GLYPH_H = 16;

    // Pause icon: two vertical bars in the top-left corner.
    localparam int unsigned PAUSE_BAR0_X = 20;
    localparam int unsigned PAUSE_BAR1_X = 40;
    localparam int unsigned PAUSE_BAR_W  = 10;
    localparam int unsigned PAUSE_Y0     = 10;
    localparam int unsigned PAUSE_Y1     = 30;

    typedef enum logic [2:0] {R_BG, R_BORDER, R_LOCKED, R_PIECE, R_PAUSE, R_TEXT} region_e;

    function automatic rgb_t region_colour(region_e region);
        rgb_t c;
        case (region)
            R_TEXT:   c = COL_TEXT;
            R_PAUSE:  c = COL_PAUSE;
            R_PIECE:  c = COL_PIECE;
            R_LOCKED: c = COL_LOCKED;
            R_BORDER: c = COL_BORDER;
            default:  c = COL_BG;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Saturating BCD score with a frame-latched copy for display.
module bcd_score_counter #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  inc,
    input  logic                  clear,
    input  logic                  latch,
    output logic [4*DIGITS-1:0]   live,
    output logic [4*DIGITS-1:0]   shown
);
    logic [4*DIGITS-1:0] live_q, live_d, shown_q;
    logic                carry;
    logic                at_max;

    always_comb begin
        live_d = live_q;
        carry  = inc;
        at_max = (live_q == {DIGITS{4'd9}});
        if (clear) begin
            live_d = '0;
        end else if (!at_max) begin
            for (int d = 0; d < int'(DIGITS); d++) begin
                if (carry) begin
                    if (live_q[4*d +: 4] == 4'd9) begin
                        live_d[4*d +: 4] = 4'd0;
                    end else begin
                        live_d[4*d +: 4] = live_q[4*d +: 4] + 4'd1;
                        carry            = 1'b0;
                    end
                end
            end
        end
    end

    // The latch captures the pre-update value, so an inc on the latch cycle shows next frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            live_q  <= '0;
            shown_q <= '0;
        end else begin
            live_q <= live_d;
            if (latch) begin
                shown_q <= live_q;
            end
        end
    end

    assign live  = live_q;
    assign shown = shown_q;

endmodule

// File: rtl/font_rom.sv
// 8x16 glyph ROM with a registered address; data follows the address by one clock.
module font_rom (
    input  logic        clk,
    input  logic [11:0] addr,
    output logic [7:0]  data
);
    logic [11:0]  addr_q;
    logic [127:0] glyph;

    always_ff @(posedge clk) begin
        addr_q <= addr;
    end

    // Each glyph packs rows 0..15 from MSB down, bit 7 of a row is the leftmost pixel.
    always_comb begin
        glyph = '0;
        case (addr_q[11:4])
            8'h30: glyph = 128'h00007CC6C6CEDEF6E6C6C67C00000000;
            8'h31: glyph = 128'h00001838781818181818187E00000000;
            8'h32: glyph = 128'h00007CC6060C183060C0C6FE00000000;
            8'h33: glyph = 128'h00007CC606063C060606C67C00000000;
            8'h34: glyph = 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
            8'h35: glyph = 128'h0000FEC0C0C0FC060606C67C00000000;
            8'h36: glyph = 128'h00003860C0C0FCC6C6C6C67C00000000;
            8'h37: glyph = 128'h0000FEC606060C183030303000000000;
            8'h38: glyph = 128'h00007CC6C6C67CC6C6C6C67C00000000;
            8'h39: glyph = 128'h00007CC6C6C67E0606060C7800000000;
            8'h43: glyph = 128'h00003C66C2C0C0C0C0C2663C00000000;
            8'h45: glyph = 128'h0000FE6662687868606266FE00000000;
            8'h4F: glyph = 128'h00007CC6C6C6C6C6C6C6C67C00000000;
            8'h52: glyph = 128'h0000FC6666667C6C666666E600000000;
            8'h53: glyph = 128'h00007CC6C660380C06C6C67C00000000;
            default: glyph = '0;
        endcase
    end

    assign data = 8'(glyph >> {4'd15 - addr_q[3:0], 3'b000});

endmodule

// File: rtl/tetris_pixel_pipe.sv
// Tetris pixel renderer: field, active piece, score text and pause icon, 2-cycle latency.
// Define PAUSE_BLINK_EN to make the pause icon blink with period BLINK_FRAMES frames.
module tetris_pixel_pipe
    import tetris_pkg::*;
#(
    parameter int unsigned N_CELLS      = 4,
    parameter int unsigned GRID_COLS    = 10,
    parameter int unsigned GRID_ROWS    = 20,
    parameter int unsigned CELL_LOG2    = 4,
    parameter int unsigned FIELD_X0     = 200,
    parameter int unsigned FIELD_Y0     = 40,
    parameter int unsigned BORDER_PX    = 8,
    parameter int unsigned SCORE_DIGITS = 4,
    parameter int unsigned TEXT_X0      = 460,
    parameter int unsigned TEXT_Y0      = 100,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic                           pix_valid,
    input  logic [9:0]                     DrawX,
    input  logic [9:0]                     DrawY,
    input  logic                           frame_start,
    input  logic [GRID_ROWS*GRID_COLS-1:0] grid,
    input  logic [N_CELLS*4-1:0]           cell_col,
    input  logic [N_CELLS*5-1:0]           cell_row,
    input  logic [N_CELLS-1:0]             cell_en,
    input  logic                           score_inc,
    input  logic                           score_clear,
    input  logic                           pause_enable,
    output logic [7:0]                     Red,
    output logic [7:0]                     Green,
    output logic [7:0]                     Blue,
    output logic                           out_valid
);
    localparam int unsigned GridN  = GRID_ROWS * GRID_COLS;
    localparam int unsigned FieldW = GRID_COLS << CELL_LOG2;
    localparam int unsigned FieldH = GRID_ROWS << CELL_LOG2;
    localparam int unsigned TextW  = GLYPH_W * (6 + SCORE_DIGITS);

    logic [31:0]               px, py, fdx, fdy, cell_c, cell_r, txt_k;
    logic [4*SCORE_DIGITS-1:0] live_score, shown_score;
    logic                      in_field, in_text, border_hit, piece_hit, locked_hit, pause_hit;
    logic                      blink_on;
    logic [GridN-1:0]          grid_mask;
    logic [3:0]                digit;
    logic [7:0]                code;
    logic [11:0]               font_addr;
    logic [7:0]                rom_data;
    logic [2:0]                txt_bit;
    region_e                   region;

    logic    valid_q, text_q;
    logic [2:0] bit_q;
    region_e region_q;
    rgb_t    rgb_q;

    bcd_score_counter #(
        .DIGITS (SCORE_DIGITS)
    ) u_score (
        .clk     (Clk),
        .reset_n (Reset_n),
        .inc     (score_inc),
        .clear   (score_clear),
        .latch   (frame_start),
        .live    (live_score),
        .shown   (shown_score)
    );

`ifdef PAUSE_BLINK_EN
    localparam int unsigned FcW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [FcW-1:0] frame_cnt;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            frame_cnt <= '0;
        end else if (frame_start) begin
            frame_cnt <= (32'(frame_cnt) == BLINK_FRAMES - 1) ? '0 : frame_cnt + FcW'(1);
        end
    end

    assign blink_on = 32'(frame_cnt) < BLINK_FRAMES / 2;
`else
    assign blink_on = 1'b1;
`endif

    assign px     = {22'd0, DrawX};
    assign py     = {22'd0, DrawY};
    assign fdx    = px - FIELD_X0;
    assign fdy    = py - FIELD_Y0;
    assign cell_c = fdx >> CELL_LOG2;
    assign cell_r = fdy >> CELL_LOG2;
    assign txt_k  = (px - TEXT_X0) >> 3;
    assign txt_bit = 3'(px - TEXT_X0);

    assign in_field = px >= FIELD_X0 && px < FIELD_X0 + FieldW &&
                      py >= FIELD_Y0 && py < FIELD_Y0 + FieldH;
    assign in_text  = px >= TEXT_X0 && px < TEXT_X0 + TextW &&
                      py >= TEXT_Y0 && py < TEXT_Y0 + GLYPH_H;

    // Border is the outer rectangle (no top edge) minus the field itself.
    assign border_hit = !in_field && px + BORDER_PX >= FIELD_X0 &&
                        px < FIELD_X0 + FieldW + BORDER_PX &&
                        py >= FIELD_Y0 && py < FIELD_Y0 + FieldH + BORDER_PX;

    assign grid_mask  = {{(GridN-1){1'b0}}, 1'b1} << (cell_r * GRID_COLS + cell_c);
    assign locked_hit = in_field && |(grid & grid_mask);

    assign pause_hit = pause_enable && blink_on && py >= PAUSE_Y0 && py < PAUSE_Y1 &&
                       ((px >= PAUSE_BAR0_X && px < PAUSE_BAR0_X + PAUSE_BAR_W) ||
                        (px >= PAUSE_BAR1_X && px < PAUSE_BAR1_X + PAUSE_BAR_W));

    always_comb begin
        piece_hit = 1'b0;
        for (int i = 0; i < int'(N_CELLS); i++) begin
            if (in_field && cell_en[i] && {28'd0, cell_col[4*i +: 4]} == cell_c &&
                {27'd0, cell_row[5*i +: 5]} == cell_r) begin
                piece_hit = 1'b1;
            end
        end
    end

    always_comb begin
        if (pause_hit)       region = R_PAUSE;
        else if (piece_hit)  region = R_PIECE;
        else if (locked_hit) region = R_LOCKED;
        else if (border_hit) region = R_BORDER;
        else                 region = R_BG;
    end

    // Text row: "SCORE " followed by the displayed digits, most significant first.
    always_comb begin
        code  = ASC_SPACE;
        digit = '0;
        if (txt_k < 32'd6) begin
            case (txt_k)
                32'd0:   code = ASC_S;
                32'd1:   code = ASC_C;
                32'd2:   code = ASC_O;
                32'd3:   code = ASC_R;
                32'd4:   code = ASC_E;
                default: code = ASC_SPACE;
            endcase
        end else begin
            digit = 4'(shown_score >> (4 * (SCORE_DIGITS - 1 - (txt_k - 32'd6))));
            code  = ASC_ZERO + {4'd0, digit};
        end
    end

    assign font_addr = {code, 4'(py - TEXT_Y0)};

    font_rom u_font (
        .clk  (Clk),
        .addr (font_addr),
        .data (rom_data)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            valid_q  <= 1'b0;
            text_q   <= 1'b0;
            bit_q    <= '0;
            region_q <= R_BG;
        end else begin
            valid_q  <= pix_valid;
            text_q   <= in_text;
            bit_q    <= txt_bit;
            region_q <= region;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            out_valid <= 1'b0;
            rgb_q     <= COL_BG;
        end else begin
            out_valid <= valid_q;
            if (!valid_q) begin
                rgb_q <= COL_BG;
            end else if (text_q && rom_data[3'd7 - bit_q]) begin
                rgb_q <= COL_TEXT;
            end else begin
                rgb_q <= region_colour(region_q);
            end
        end
    end

    assign Red   = rgb_q.r;
    assign Green = rgb_q.g;
    assign Blue  = rgb_q.b;

endmodule

// File: tb/tb_tetris_pixel_pipe.sv
// Scoreboard bench for tetris_pixel_pipe: directed scenarios plus randomized pixels.
module tb_tetris_pixel_pipe;

    localparam int NC = 4, COLS = 10, ROWS = 20, SD = 4, BLINK = 32;
    localparam int FX0 = 200, FY0 = 40, CELL = 16, BPX = 8, TX0 = 460, TY0 = 100;
    localparam int FW = COLS * CELL, FH = ROWS * CELL;
    localparam int MAXSCORE = 9999;

    logic               Clk = 1'b0;
    logic               Reset_n = 1'b0, pix_valid = 1'b0, frame_start = 1'b0;
    logic               score_inc = 1'b0, score_clear = 1'b0, pause_enable = 1'b0;
    logic [9:0]         DrawX = '0, DrawY = '0;
    logic [ROWS*COLS-1:0] grid = '0;
    logic [NC*4-1:0]    cell_col = '0;
    logic [NC*5-1:0]    cell_row = '0;
    logic [NC-1:0]      cell_en = '0;
    logic [7:0]         Red, Green, Blue;
    logic               out_valid;

    tetris_pixel_pipe #(
        .N_CELLS(NC), .GRID_COLS(COLS), .GRID_ROWS(ROWS), .CELL_LOG2(4),
        .FIELD_X0(FX0), .FIELD_Y0(FY0), .BORDER_PX(BPX), .SCORE_DIGITS(SD),
        .TEXT_X0(TX0), .TEXT_Y0(TY0), .BLINK_FRAMES(BLINK)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
        .frame_start(frame_start), .grid(grid), .cell_col(cell_col), .cell_row(cell_row),
        .cell_en(cell_en), .score_inc(score_inc), .score_clear(score_clear),
        .pause_enable(pause_enable), .Red(Red), .Green(Green), .Blue(Blue),
        .out_valid(out_valid)
    );

    always #5 Clk = ~Clk;

    int unsigned cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic        v;
        logic [23:0] rgb;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0, miscompares = 0;

    // Reference state: live/displayed score as integers, frame count modulo BLINK.
    int m_live = 0, m_shown = 0, m_fcnt = 0;
    logic [47:0] label = "SCORE ";

    function automatic logic [127:0] tb_glyph(input logic [7:0] code);
        case (code)
            8'h30: return 128'h00007CC6C6CEDEF6E6C6C67C00000000;
            8'h31: return 128'h00001838781818181818187E00000000;
            8'h32: return 128'h00007CC6060C183060C0C6FE00000000;
            8'h33: return 128'h00007CC606063C060606C67C00000000;
            8'h34: return 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
            8'h35: return 128'h0000FEC0C0C0FC060606C67C00000000;
            8'h36: return 128'h00003860C0C0FCC6C6C6C67C00000000;
            8'h37: return 128'h0000FEC606060C183030303000000000;
            8'h38: return 128'h00007CC6C6C67CC6C6C6C67C00000000;
            8'h39: return 128'h00007CC6C6C67E0606060C7800000000;
            8'h43: return 128'h00003C66C2C0C0C0C0C2663C00000000;
            8'h45: return 128'h0000FE6662687868606266FE00000000;
            8'h4F: return 128'h00007CC6C6C6C6C6C6C6C67C00000000;
            8'h52: return 128'h0000FC6666667C6C666666E600000000;
            8'h53: return 128'h00007CC6C660380C06C6C67C00000000;
            default: return 128'h0;
        endcase
    endfunction

    function automatic logic [23:0] model_pix(input int x, input int y);
        int k, v, c, r;
        logic [7:0] code, rowb;
        logic [127:0] g;
        logic blink;
        if (y >= TY0 && y < TY0 + 16 && x >= TX0 && x < TX0 + 8 * (6 + SD)) begin
            k = (x - TX0) / 8;
            if (k < 6) begin
                code = label[47 - 8*k -: 8];
            end else begin
                v = m_shown;
                for (int i = 0; i < SD - 1 - (k - 6); i++) v = v / 10;
                code = 8'(48 + v % 10);
            end
            g = tb_glyph(code);
            rowb = g[127 - 8*(y - TY0) -: 8];
            if (rowb[7 - ((x - TX0) % 8)]) return 24'h00FFFF;
        end
`ifdef PAUSE_BLINK_EN
        blink = (m_fcnt < BLINK / 2);
`else
        blink = 1'b1;
`endif
        if (pause_enable && blink && y >= 10 && y < 30 &&
            ((x >= 20 && x < 30) || (x >= 40 && x < 50))) return 24'hFFFFFF;
        if (x >= FX0 && x < FX0 + FW && y >= FY0 && y < FY0 + FH) begin
            c = (x - FX0) / CELL;
            r = (y - FY0) / CELL;
            for (int i = 0; i < NC; i++)
                if (cell_en[i] && int'(cell_col[4*i +: 4]) == c && int'(cell_row[5*i +: 5]) == r)
                    return 24'hFFFF00;
            if (grid[r * COLS + c]) return 24'hFF1493;
            return 24'h000000;
        end
        if (x >= FX0 - BPX && x < FX0 + FW + BPX && y >= FY0 && y < FY0 + FH + BPX)
            return 24'hFFFFFF;
        return 24'h000000;
    endfunction

    // Drive one cycle, push its expected output (due 2 cycles later), advance the model.
    task automatic step(input logic rn, input logic pv, input int x, input int y,
                        input logic fs, input logic inc, input logic clr);
        exp_t e;
        Reset_n = rn; pix_valid = pv; DrawX = 10'(x); DrawY = 10'(y);
        frame_start = fs; score_inc = inc; score_clear = clr;
        // A reset edge also wipes the pixel that was about to leave stage 2.
        if (!rn && sb.size() > 0 && sb[sb.size()-1].cyc == cyc + 1) begin
            e = sb.pop_back();
            e.v = 1'b0;
            e.rgb = '0;
            sb.push_back(e);
        end
        e.cyc = cyc + 2;
        e.v   = rn && pv;
        e.rgb = e.v ? model_pix(x, y) : 24'h0;
        sb.push_back(e);
        if (!rn) begin
            m_live = 0; m_shown = 0; m_fcnt = 0;
        end else begin
            if (fs) begin
                m_shown = m_live;
                m_fcnt  = (m_fcnt + 1) % BLINK;
            end
            if (clr) m_live = 0;
            else if (inc && m_live < MAXSCORE) m_live++;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic pix(input int x, input int y);
        step(1'b1, 1'b1, x, y, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic fs, input logic inc, input logic clr);
        step(1'b1, 1'b0, 0, 0, fs, inc, clr);
    endtask

    task automatic scan_text(input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = TX0 - 4; x < TX0 + 8 * (6 + SD) + 4; x++) pix(x, y);
    endtask

    task automatic randomize_field();
        for (int i = 0; i < ROWS * COLS; i++) grid[i] = ($urandom_range(0, 2) == 0);
        for (int i = 0; i < NC; i++) begin
            cell_col[4*i +: 4] = 4'($urandom_range(0, 11));
            cell_row[5*i +: 5] = 5'($urandom_range(0, 21));
        end
        cell_en = 4'($urandom);
    endtask

    exp_t me;
    always @(negedge Clk) begin
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            me = sb.pop_front();
            vectors++;
            if (out_valid !== me.v || {Red, Green, Blue} !== me.rgb) begin
                miscompares++;
                $display("FAIL pixel cyc=%0d: got valid=%b rgb=%06h, expected valid=%b rgb=%06h",
                         cyc, out_valid, {Red, Green, Blue}, me.v, me.rgb);
            end
        end else if (out_valid !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL orphan cyc=%0d: got out_valid=%b, expected 0", cyc, out_valid);
        end
    end

    initial begin
        @(posedge Clk);
        #1;
        // Reset held with valid pixels presented: output must stay black and invalid.
        step(1'b0, 1'b1, 200, 40, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 200, 40, 1'b0, 1'b0, 1'b0);

        // Locked cell, then active piece on top of it.
        grid[0] = 1'b1;
        pix(200, 40);
        pix(215, 55);
        cell_en = 4'b0001;
        cell_col = '0;
        cell_row = '0;
        pix(200, 40);
        pix(216, 40);

        // Border and off-field corners.
        pix(199, 40);
        pix(192, 200);
        pix(191, 200);
        pix(FX0 + FW, FY0);
        pix(FX0 + FW + BPX - 1, FY0 + FH + BPX - 1);
        pix(FX0 + FW + BPX, FY0);
        pix(250, FY0 + FH + 3);
        pix(250, 39);
        pix(639, 479);

        // Score text: 12 increments, latched, then a same-cycle inc+latch.
        for (int i = 0; i < 12; i++) idle(1'b0, 1'b1, 1'b0);
        idle(1'b1, 1'b0, 1'b0);
        scan_text(TY0, TY0 + 15);
        idle(1'b1, 1'b1, 1'b0);
        scan_text(TY0, TY0 + 15);
        idle(1'b1, 1'b0, 1'b0);
        scan_text(TY0, TY0 + 15);

        // Saturation at 9999, then clear beating inc.
        idle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < MAXSCORE; i++) idle(1'b0, 1'b1, 1'b0);
        idle(1'b1, 1'b0, 1'b0);
        scan_text(TY0 + 4, TY0 + 6);
        idle(1'b0, 1'b1, 1'b0);
        idle(1'b1, 1'b0, 1'b0);
        scan_text(TY0 + 5, TY0 + 7);
        idle(1'b0, 1'b1, 1'b1);
        idle(1'b1, 1'b0, 1'b0);
        scan_text(TY0 + 3, TY0 + 5);

        // Pause icon across more than one blink period.
        pause_enable = 1'b1;
        for (int f = 0; f < BLINK + 4; f++) begin
            idle(1'b1, 1'b0, 1'b0);
            pix(25, 15);
            pix(49, 29);
            pix(35, 15);
            pix(25, 30);
        end
        pause_enable = 1'b0;
        pix(25, 15);

        // Randomized pixels with background score, frame and reset activity.
        for (int n = 0; n < 1500; n++) begin
            int x, y;
            if (n % 250 == 0) randomize_field();
            if ($urandom_range(0, 15) == 0) pause_enable = ~pause_enable;
            case ($urandom_range(0, 3))
                0: begin x = $urandom_range(180, 380); y = $urandom_range(30, 380); end
                1: begin x = $urandom_range(450, 550); y = $urandom_range(95, 120); end
                2: begin x = $urandom_range(10, 60);   y = $urandom_range(0, 40);   end
                default: begin x = $urandom_range(0, 639); y = $urandom_range(0, 479); end
            endcase
            step((n == 700) ? 1'b0 : 1'b1, $urandom_range(0, 9) != 0, x, y,
                 $urandom_range(0, 40) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 80) == 0);
        end

        pix_valid = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pixels still pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
